// File: rtl/mult_seq.sv
// Sequential shift-add unsigned multiplier, K multiplier bits retired per cycle.
// Define MULT_SEQ_ACC_EN to add acc_clr and a running multiply-accumulate register.
module mult_seq #(
    parameter int unsigned W = 16,
    parameter int unsigned K = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     x,
    input  logic [W-1:0]     y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   p_out
`ifdef MULT_SEQ_ACC_EN
    ,
    input  logic             acc_clr
`endif
);

    localparam int unsigned PW    = 2 * W;
    localparam int unsigned STEPS = W / K;
    localparam int unsigned CW    = $clog2(STEPS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [PW-1:0]   mcand_q;
    logic [W-1:0]    mplier_q;
    logic [PW-1:0]   pp_q;
    logic [PW-1:0]   pp_d;
    logic [PW-1:0]   p_q;
    logic [CW-1:0]   cnt_q;
    logic            out_valid_q;
`ifdef MULT_SEQ_ACC_EN
    logic [PW-1:0]   acc_q;
`endif

    // Acceptance is gated by rst so no operand is taken during a reset cycle.
    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign p_out     = p_q;

    // One radix-2^K step: add the shifted multiplicand for each set low multiplier bit.
    always_comb begin
        pp_d = pp_q;
        for (int j = 0; j < int'(K); j++) begin
            if (mplier_q[j]) begin
                pp_d = pp_d + (mcand_q << j);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            pp_q        <= '0;
            p_q         <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
`ifdef MULT_SEQ_ACC_EN
            acc_q       <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        mcand_q  <= PW'(x);
                        mplier_q <= y;
                        cnt_q    <= '0;
                        // Seeding the partial product folds the accumulate into the shift-add.
`ifdef MULT_SEQ_ACC_EN
                        pp_q     <= acc_clr ? '0 : acc_q;
`else
                        pp_q     <= '0;
`endif
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    pp_q     <= pp_d;
                    mcand_q  <= mcand_q << K;
                    mplier_q <= mplier_q >> K;
                    cnt_q    <= cnt_q + CW'(1);
                    if (cnt_q == CW'(STEPS - 1)) begin
                        p_q         <= pp_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
`ifdef MULT_SEQ_ACC_EN
                        acc_q       <= pp_d;
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq.sv
// Bench for mult_seq: two instances (K=1, K=2, W=16) checked each cycle against a
// cycle-count transaction model, plus directed vectors with literal expected products.
module tb_mult_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        iv   [2];
    logic        ordy [2];
    logic        clr  [2];
    logic [15:0] xa   [2];
    logic [15:0] ya   [2];
    logic        ir   [2];
    logic        ov   [2];
    logic [31:0] pa   [2];

    logic        ir0, ir1, ov0, ov1;
    logic [31:0] p0, p1;

    mult_seq #(.W(16), .K(1)) u_k1 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir0),
        .x(xa[0]), .y(ya[0]), .out_valid(ov0), .out_ready(ordy[0]), .p_out(p0)
`ifdef MULT_SEQ_ACC_EN
        , .acc_clr(clr[0])
`endif
    );

    mult_seq #(.W(16), .K(2)) u_k2 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir1),
        .x(xa[1]), .y(ya[1]), .out_valid(ov1), .out_ready(ordy[1]), .p_out(p1)
`ifdef MULT_SEQ_ACC_EN
        , .acc_clr(clr[1])
`endif
    );

    always_comb begin
        ir[0] = ir0; ir[1] = ir1;
        ov[0] = ov0; ov[1] = ov1;
        pa[0] = p0;  pa[1] = p1;
    end

    int nerr = 0;
    int nchk = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: an accepted pair becomes visible W/K edges later until consumed.
    bit          m_idle [2];
    int          m_left [2];
    bit          m_done [2];
    logic [31:0] m_p    [2];
    logic [31:0] m_acc  [2];
    logic [31:0] m_x    [2];
    logic [31:0] m_y    [2];
    bit          m_clr  [2];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_idle[d] = 1'b1; m_left[d] = 0; m_done[d] = 1'b0;
                m_p[d] = '0; m_acc[d] = '0;
            end else if (m_idle[d] && iv[d]) begin
                m_idle[d] = 1'b0;
                m_left[d] = (d == 0) ? 16 : 8;
                m_x[d] = 32'(xa[d]); m_y[d] = 32'(ya[d]); m_clr[d] = clr[d];
            end else if (m_left[d] > 0) begin
                m_left[d] = m_left[d] - 1;
                if (m_left[d] == 0) begin
                    m_done[d] = 1'b1;
`ifdef MULT_SEQ_ACC_EN
                    m_p[d] = (m_clr[d] ? 32'd0 : m_acc[d]) + m_x[d] * m_y[d];
`else
                    m_p[d] = m_x[d] * m_y[d];
`endif
                    m_acc[d] = m_p[d];
                end
            end else if (m_done[d] && ordy[d]) begin
                m_done[d] = 1'b0;
                m_idle[d] = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("model_in_ready%0d", d), 64'(ir[d]), 64'(m_idle[d] && !rst));
                chk($sformatf("model_out_valid%0d", d), 64'(ov[d]), 64'(m_done[d]));
                chk($sformatf("model_p_out%0d", d), 64'(pa[d]), 64'(m_p[d]));
            end
        end
    end

    task automatic op(input int d, input logic [15:0] a, input logic [15:0] b, input logic c,
                      output int lat, output logic [31:0] res);
        int g;
        g = 0;
        while (!ir[d] && g < 50) begin
            @(posedge clk); #1; g++;
        end
        iv[d] = 1'b1; xa[d] = a; ya[d] = b; clr[d] = c;
        @(posedge clk); #1;
        iv[d] = 1'b0;
        lat = 0;
        while (!ov[d] && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        res = pa[d];
    endtask

    int          lat;
    int          n;
    logic [31:0] res;

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            iv[d] = 1'b0; ordy[d] = 1'b1; clr[d] = 1'b1; xa[d] = '0; ya[d] = '0;
        end
        @(posedge clk); #1;
        chk_en = 1'b1;
        chk("rst_in_ready", 64'(ir[0]), 64'd0);
        @(posedge clk); #1;
        chk("rst_p_out", 64'(pa[0]), 64'd0);
        chk("rst_out_valid", 64'(ov[0]), 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(ir[0]), 64'd1);

        // Full-scale operands, K=1
        op(0, 16'hFFFF, 16'hFFFF, 1'b1, lat, res);
        chk("k1_max_latency", 64'(lat), 64'd16);
        chk("k1_max_product", 64'(res), 64'hFFFE0001);

        // K=2 halves the latency
        op(1, 16'h1234, 16'h5678, 1'b1, lat, res);
        chk("k2_latency", 64'(lat), 64'd8);
        chk("k2_product", 64'(res), 64'h06260060);

        op(1, 16'h0000, 16'hABCD, 1'b1, lat, res);
        chk("k2_zero_latency", 64'(lat), 64'd8);
        chk("k2_zero_product", 64'(res), 64'd0);

        // Backpressure in DONE and ignored in_valid pulses
        @(posedge clk); #1;
        ordy[0] = 1'b0;
        iv[0] = 1'b1; xa[0] = 16'h00FF; ya[0] = 16'h0101;
        @(posedge clk); #1;
        iv[0] = 1'b0; xa[0] = 16'h1234; ya[0] = 16'h1234;
        n = 1;
        while (!ov[0] && n < 100) begin
            iv[0] = ~iv[0];
            chk("busy_in_ready", 64'(ir[0]), 64'd0);
            @(posedge clk); #1; n++;
        end
        chk("bp_latency", 64'(n - 1), 64'd16);
        for (int i = 0; i < 5; i++) begin
            iv[0] = 1'b1;
            chk("bp_out_valid", 64'(ov[0]), 64'd1);
            chk("bp_p_out", 64'(pa[0]), 64'h0000FFFF);
            chk("done_in_ready", 64'(ir[0]), 64'd0);
            @(posedge clk); #1;
        end
        iv[0] = 1'b0; ordy[0] = 1'b1;
        @(posedge clk); #1;
        chk("bp_released_valid", 64'(ov[0]), 64'd0);
        chk("idle_p_hold", 64'(pa[0]), 64'h0000FFFF);

        // Reset in the middle of BUSY
        iv[0] = 1'b1; xa[0] = 16'hFFFF; ya[0] = 16'hFFFF;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_out_valid", 64'(ov[0]), 64'd0);
        chk("abort_p_out", 64'(pa[0]), 64'd0);
        chk("abort_in_ready_rst", 64'(ir[0]), 64'd0);
        rst = 1'b0;
        #1;
        chk("abort_in_ready", 64'(ir[0]), 64'd1);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk("abort_no_stale", 64'(ov[0]), 64'd0);
        end

        // Back-to-back with out_ready tied high
        iv[0] = 1'b1; xa[0] = 16'h0000; ya[0] = 16'hABCD;
        @(posedge clk); #1;
        xa[0] = 16'h0001; ya[0] = 16'h0001;
        n = 0;
        while (!ov[0] && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("b2b_first_latency", 64'(n), 64'd16);
        chk("b2b_first_product", 64'(pa[0]), 64'd0);
        @(posedge clk); #1;
        chk("b2b_gap_valid", 64'(ov[0]), 64'd0);
        chk("b2b_gap_ready", 64'(ir[0]), 64'd1);
        @(posedge clk); #1;
        chk("b2b_second_accepted", 64'(ir[0]), 64'd0);
        iv[0] = 1'b0;
        n = 0;
        while (!ov[0] && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("b2b_second_latency", 64'(n), 64'd16);
        chk("b2b_second_product", 64'(pa[0]), 64'd1);

`ifdef MULT_SEQ_ACC_EN
        // Multiply-accumulate chain
        op(0, 16'd3, 16'd4, 1'b1, lat, res);
        chk("acc_first", 64'(res), 64'd12);
        op(0, 16'd5, 16'd6, 1'b0, lat, res);
        chk("acc_second", 64'(res), 64'd42);
        op(0, 16'hFFFF, 16'hFFFF, 1'b0, lat, res);
        chk("acc_third", 64'(res), 64'hFFFE002B);
        chk("acc_latency", 64'(lat), 64'd16);
        clr[0] = 1'b1;
`endif

        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", nerr);
        $fatal(1);
    end

endmodule

// File: doc/mult_seq.md
MULT_SEQ -- requirements
Module: mult_seq

Interface
REQ-001 SHALL have parameter W, default 16: operand width in bits; legal range 4..64.
REQ-002 SHALL have parameter K, default 1: multiplier bits retired per cycle; legal values 1, 2, 4; W SHALL be divisible by K.
REQ-003 SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1: operand pair x, y present.
REQ-006 SHALL have port in_ready  output  1: block can accept operands.
REQ-007 SHALL have port x  input  W: unsigned multiplicand.
REQ-008 SHALL have port y  input  W: unsigned multiplier.
REQ-009 SHALL have port out_valid  output  1: p_out holds a completed result.
REQ-010 SHALL have port out_ready  input  1: consumer accepts p_out.
REQ-011 SHALL have port p_out  output  2W: registered product.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-013 SHALL drive in_ready high only in IDLE with rst low; out_valid SHALL be high only in DONE.
REQ-014 SHALL capture x, y and go IDLE->BUSY on any edge where in_valid and in_ready are both high; x, y at other times SHALL be ignored.
REQ-015 SHALL, in BUSY, perform shift-add over K multiplier bits per cycle (LSB first) using a 2W-bit partial product and a counter of ceil(log2(W/K+1)) bits.
REQ-016 SHALL go BUSY->DONE exactly W/K edges after the accepting edge; out_valid therefore first goes high W/K cycles after acceptance (16 for W=16, K=1; 8 for K=2).
REQ-017 SHALL load p_out on the BUSY->DONE edge and hold p_out and out_valid stable while out_ready is low.
REQ-018 SHALL go DONE->IDLE on the edge where out_valid and out_ready are both high; p_out SHALL keep its last value in IDLE and BUSY.
REQ-019 SHALL compute p_out = x*y exactly; no truncation or overflow is possible at 2W bits.
REQ-020 SHALL ignore out_ready outside DONE and in_valid outside IDLE; neither SHALL affect state.
REQ-021 SHALL, on operand 0 in x or y, still take the full W/K BUSY cycles (no early termination) and return 0.

Reset
REQ-022 SHALL, on any edge with rst high, force state to IDLE, out_valid to 0, p_out to 0, counter and partial product to 0, and accumulator (if compiled in) to 0.
REQ-023 SHALL hold in_ready low on every cycle rst is high; first acceptance possible on the first edge after rst falls.
REQ-024 SHALL abort any BUSY or DONE operation on reset; the aborted result SHALL never appear with out_valid high.

Configuration
REQ-025 SHALL, when macro MULT_SEQ_ACC_EN is defined, add input port acc_clr (1 bit, sampled with x, y on the accepting edge) and a 2W-bit accumulator register.
REQ-026 SHALL, with MULT_SEQ_ACC_EN defined, produce p_out = (acc_clr ? 0 : acc) + x*y modulo 2^(2W), and update acc to that p_out on the BUSY->DONE edge.
REQ-027 SHALL, with MULT_SEQ_ACC_EN undefined, omit acc_clr and the accumulator entirely; p_out = x*y; latency identical in both builds.

Verification
REQ-028 SHALL cover: reset, then W=16, K=1, x=0xFFFF, y=0xFFFF accepted -> out_valid high exactly 16 cycles later, p_out=0xFFFE0001.
REQ-029 SHALL cover: K=2, x=0x1234, y=0x5678 -> out_valid after 8 cycles, p_out=0x06260060.
REQ-030 SHALL cover: out_ready held low 5 cycles in DONE -> p_out and out_valid stable; in_valid pulses during BUSY/DONE not accepted (in_ready low).
REQ-031 SHALL cover: rst asserted at BUSY cycle 7 -> next cycle out_valid=0, p_out=0, in_ready high after rst low; no stale result ever emitted.
REQ-032 SHALL cover (MULT_SEQ_ACC_EN): ops (3,4,acc_clr=1), (5,6,0), (0xFFFF,0xFFFF,0) -> p_out 12, 42, 0xFFFE002B.
REQ-033 SHALL cover: back-to-back ops with out_ready tied high, x=0 y=0xABCD then x=1 y=1 -> results 0 then 1, each after 16 cycles, one IDLE cycle between.
